rr_priority_arbiter: RTL and testbench

Sequential arbiter that shares one resource among 16 requesters. It uses a 16-bit lowest-set-bit priority encode: the lowest index wins, and an all-zero input encodes to 0 but is qualified by an any-bit flag. The encode runs either with fixed priority or on a request vector rotated by a round-robin pointer. The block issues one grant at a time, runs a valid/ready offer handshake with the resource, tracks ownership until release, and pre-empts owners that exceed a hold limit.

---
 rtl/rr_priority_arbiter.sv | 131 +++++++++++++
 tb/tb_rr_priority_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/rr_priority_arbiter.sv
// rr_priority_arbiter: shares one resource among 16 requesters.
// Picks a winner (fixed lowest-index or round-robin from ptr), offers it to the
// resource with a valid/ready handshake, tracks ownership until release, and
// pre-empts an owner that holds the resource for MAX_HOLD cycles.
// The owner's release input is named gnt_release because "release" is a
// reserved word in SystemVerilog.
module rr_priority_arbiter #(
    parameter int MAX_HOLD = 255,
    parameter int CNT_W    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    input  logic        rr_en,
    input  logic        gnt_ready,
    input  logic        gnt_release,
    output logic        gnt_valid,
    output logic [3:0]  gnt_id,
    output logic [15:0] gnt_onehot,
    output logic        busy,
    output logic        timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        BUSY  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] HOLD_SAT  = {CNT_W{1'b1}};

    state_t           state_q;
    state_t           state_d;
    logic [3:0]       ptr_q;
    logic [3:0]       ptr_d;
    logic [3:0]       id_d;
    logic [CNT_W-1:0] hold_q;
    logic [CNT_W-1:0] hold_d;
    logic             timeout_d;

    logic [3:0]       base;
    logic [15:0]      rot;
    logic [3:0]       winner;
    logic             any;

    // Lowest set bit of a 16-bit vector; an all-zero vector encodes to 0.
    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    // Fixed mode is round-robin with base 0: rotate right, encode, add base back.
    always_comb begin
        any  = |req;
        base = rr_en ? ptr_q : 4'd0;
        rot  = '0;
        for (int i = 0; i < 16; i++) begin
            rot[i] = req[4'(i) + base];
        end
        winner = lowest_set(rot) + base;
    end

    // Next-state logic: grant selection, offer handshake, ownership and pre-emption.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = gnt_id;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (any) begin
                    id_d    = winner;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (!req[gnt_id]) begin
                    state_d = IDLE;
                end else if (gnt_ready) begin
                    state_d = BUSY;
                    hold_d  = '0;
                end
            end
            BUSY: begin
                if (gnt_release || !req[gnt_id]) begin
                    state_d = IDLE;
                    ptr_d   = gnt_id + 4'd1;
                end else if (hold_q == HOLD_LAST) begin
                    state_d   = IDLE;
                    ptr_d     = gnt_id + 4'd1;
                    timeout_d = 1'b1;
                end else if (hold_q != HOLD_SAT) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and all outputs are registered from the next-state values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= 4'd0;
            hold_q     <= '0;
            gnt_id     <= 4'd0;
            gnt_valid  <= 1'b0;
            gnt_onehot <= 16'd0;
            busy       <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_q     <= hold_d;
            gnt_id     <= id_d;
            gnt_valid  <= (state_d != IDLE);
            gnt_onehot <= (state_d != IDLE) ? (16'd1 << id_d) : 16'd0;
            busy       <= (state_d == BUSY);
            timeout    <= timeout_d;
        end
    end

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Testbench for rr_priority_arbiter: directed scenarios followed by random
// traffic, all checked every cycle against a transaction-level reference model.
module tb_rr_priority_arbiter;

    localparam int MAX_HOLD = 4;

    logic        clk;
    logic        rst_n;
    logic [15:0] req;
    logic        rr_en;
    logic        gnt_ready;
    logic        gnt_release;
    logic        gnt_valid;
    logic [3:0]  gnt_id;
    logic [15:0] gnt_onehot;
    logic        busy;
    logic        timeout;

    int nChecks = 0;
    int nPass   = 0;
    int nFail   = 0;

    // Reference model: 0 = no grant, 1 = offered, 2 = owned.
    int mPhase;
    int mId;
    int mPtr;
    int mHeld;
    bit mTimeout;

    rr_priority_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .rr_en      (rr_en),
        .gnt_ready  (gnt_ready),
        .gnt_release(gnt_release),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id),
        .gnt_onehot (gnt_onehot),
        .busy       (busy),
        .timeout    (timeout)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    // First requester at or after 'start', scanning upward with wrap.
    function automatic int pickWinner(input logic [15:0] r, input int start);
        int  w;
        bit  found;
        w = 0;
        found = 0;
        for (int k = 0; k < 16; k++) begin
            if (!found && r[(start + k) % 16]) begin
                w = (start + k) % 16;
                found = 1;
            end
        end
        return w;
    endfunction

    task automatic modelReset();
        mPhase   = 0;
        mId      = 0;
        mPtr     = 0;
        mHeld    = 0;
        mTimeout = 0;
    endtask

    // Advance the model by one clock edge using the inputs the bench applied.
    task automatic modelStep();
        mTimeout = 0;
        if (!rst_n) begin
            modelReset();
        end else if (mPhase == 0) begin
            if (req != 16'd0) begin
                mId    = pickWinner(req, rr_en ? mPtr : 0);
                mPhase = 1;
            end
        end else if (mPhase == 1) begin
            if (!req[mId]) begin
                mPhase = 0;
            end else if (gnt_ready) begin
                mPhase = 2;
                mHeld  = 0;
            end
        end else begin
            mHeld = mHeld + 1;
            if (gnt_release || !req[mId]) begin
                mPhase = 0;
                mPtr   = (mId + 1) % 16;
            end else if (mHeld == MAX_HOLD) begin
                mPhase   = 0;
                mPtr     = (mId + 1) % 16;
                mTimeout = 1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else begin
            nFail++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [15:0] expOnehot;
        expOnehot = (mPhase != 0) ? (16'd1 << mId) : 16'd0;
        chk({tag, ".valid"},   {15'd0, gnt_valid}, {15'd0, mPhase != 0});
        chk({tag, ".id"},      {12'd0, gnt_id},    16'(mId));
        chk({tag, ".onehot"},  gnt_onehot,         expOnehot);
        chk({tag, ".busy"},    {15'd0, busy},      {15'd0, mPhase == 2});
        chk({tag, ".timeout"}, {15'd0, timeout},   {15'd0, mTimeout});
    endtask

    // Drive inputs, take one clock edge, update the model, then check away from the edge.
    task automatic applyStimulus(input logic [15:0] r, input logic rr, input logic rdy,
                                 input logic rl, input string tag);
        req         = r;
        rr_en       = rr;
        gnt_ready   = rdy;
        gnt_release = rl;
        @(posedge clk);
        modelStep();
        #1;
        checkOutput(tag);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("rst");
        applyStimulus(16'h0000, 1'b0, 1'b0, 1'b0, "rstHold");
        rst_n = 1'b1;
    endtask

    logic [15:0] rReq;
    logic        rRr;
    int          rrExp[5] = '{0, 5, 15, 0, 5};

    // Directed scenarios, then random traffic, then the summary.
    initial begin
        clk = 1'b0;
        rst_n = 1'b1;
        req = '0;
        rr_en = 1'b0;
        gnt_ready = 1'b0;
        gnt_release = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("reset0");
        @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] fixed priority");
        for (int g = 0; g < 3; g++) begin
            applyStimulus(16'hC008, 1'b0, 1'b1, 1'b0, "fix.offer");
            chk("fix.id3", {12'd0, gnt_id}, 16'd3);
            applyStimulus(16'hC008, 1'b0, 1'b1, 1'b0, "fix.busy");
            applyStimulus(16'hC008, 1'b0, 1'b1, 1'b1, "fix.rel");
        end
        applyStimulus(16'h8000, 1'b0, 1'b1, 1'b0, "fix15.offer");
        chk("fix15.id", {12'd0, gnt_id}, 16'd15);
        chk("fix15.onehot", gnt_onehot, 16'h8000);
        applyStimulus(16'h8000, 1'b0, 1'b1, 1'b1, "fix15.busy");
        applyStimulus(16'h0000, 1'b0, 1'b0, 1'b0, "fix15.drop");

        $display("[TB] round-robin fairness");
        doReset();
        for (int g = 0; g < 5; g++) begin
            applyStimulus(16'h8021, 1'b1, 1'b1, 1'b0, "rr.offer");
            chk("rr.seq", {12'd0, gnt_id}, 16'(rrExp[g]));
            applyStimulus(16'h8021, 1'b1, 1'b1, 1'b0, "rr.busy");
            applyStimulus(16'h8021, 1'b1, 1'b1, 1'b0, "rr.hold");
            applyStimulus(16'h8021, 1'b1, 1'b1, 1'b1, "rr.rel");
        end

        $display("[TB] offer withdraw");
        doReset();
        applyStimulus(16'h0010, 1'b1, 1'b0, 1'b0, "wd.offer");
        for (int c = 0; c < 3; c++) applyStimulus(16'h0010, 1'b1, 1'b0, 1'b0, "wd.wait");
        applyStimulus(16'h0000, 1'b1, 1'b0, 1'b0, "wd.drop");
        chk("wd.valid", {15'd0, gnt_valid}, 16'd0);
        applyStimulus(16'h8021, 1'b1, 1'b1, 1'b0, "wd.next");
        chk("wd.ptr0", {12'd0, gnt_id}, 16'd0);
        applyStimulus(16'h0000, 1'b1, 1'b0, 1'b0, "wd.end");

        $display("[TB] timeout and collision");
        doReset();
        applyStimulus(16'h0006, 1'b1, 1'b1, 1'b0, "to.offer");
        chk("to.id1", {12'd0, gnt_id}, 16'd1);
        applyStimulus(16'h0006, 1'b1, 1'b1, 1'b0, "to.accept");
        for (int c = 0; c < MAX_HOLD; c++) applyStimulus(16'h0006, 1'b1, 1'b1, 1'b0, "to.hold");
        chk("to.pulse", {15'd0, timeout}, 16'd1);
        chk("to.validLow", {15'd0, gnt_valid}, 16'd0);
        applyStimulus(16'h0006, 1'b1, 1'b1, 1'b0, "to.next");
        chk("to.id2", {12'd0, gnt_id}, 16'd2);
        chk("to.pulseEnd", {15'd0, timeout}, 16'd0);
        applyStimulus(16'h0006, 1'b1, 1'b1, 1'b0, "col.accept");
        for (int c = 0; c < MAX_HOLD - 1; c++) applyStimulus(16'h0006, 1'b1, 1'b1, 1'b0, "col.hold");
        applyStimulus(16'h0006, 1'b1, 1'b1, 1'b1, "col.rel");
        chk("col.noTimeout", {15'd0, timeout}, 16'd0);
        chk("col.idle", {15'd0, gnt_valid}, 16'd0);

        $display("[TB] asynchronous reset mid-BUSY");
        applyStimulus(16'h0001, 1'b0, 1'b1, 1'b0, "ar.offer");
        applyStimulus(16'h0001, 1'b0, 1'b1, 1'b0, "ar.busy");
        chk("ar.busyHigh", {15'd0, busy}, 16'd1);
        #2 rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("ar.immediate");
        for (int c = 0; c < 5; c++) applyStimulus(16'h0000, 1'b0, 1'b0, 1'b0, "ar.held");
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) applyStimulus(16'h0000, 1'b1, 1'b1, 1'b0, "ar.empty");

        $display("[TB] random traffic");
        rReq = 16'h0000;
        rRr  = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) rReq = 16'($urandom) & 16'($urandom) & 16'($urandom);
            if ($urandom_range(0, 15) == 0) rRr = ~rRr;
            applyStimulus(rReq, rRr, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, "rand");
        end

        $display("[TB] %0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
